spi_master_core: RTL and testbench

MMIO slot core providing a byte-oriented SPI master with software-controlled slave selects. Attaches to one slot of the MMIO subsystem and is driven by the MMIO controller's per-slot cs/read/write/addr/wr_data signals. It returns status and receive data on rd_data. Each software write to the data register triggers one 8-bit full-duplex transfer; clock rate, CPOL and CPHA are programmable.

---
 rtl/spi_master_core.sv | 160 ++++++++++++++++
 tb/tb_spi_master_core.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_core.sv
// Byte-oriented SPI master for one MMIO slot: software-driven slave selects,
// programmable sclk divider, CPOL and CPHA, one full-duplex byte per data write.
module spi_master_core #(
    parameter int S = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cs,
    input  logic         read,
    input  logic         write,
    input  logic [4:0]   addr,
    input  logic [31:0]  wr_data,
    output logic [31:0]  rd_data,
    output logic         spi_sclk,
    output logic         spi_mosi,
    input  logic         spi_miso,
    output logic [S-1:0] spi_ss_n
);

    typedef enum logic [1:0] {
        IDLE,
        CPHA_DLY,
        P0,
        P1
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] c_reg, c_next;
    logic [2:0]  n_reg, n_next;
    logic [7:0]  tx_shift_reg, tx_shift_next;
    logic [7:0]  rx_shift_reg, rx_shift_next;
    logic [7:0]  rx_data_reg, rx_data_next;

    logic [S-1:0] ss_n_reg;
    logic [15:0]  dvsr_reg, dvsr_s_reg;
    logic         cpol_reg, cpol_s_reg;
    logic         cpha_reg, cpha_s_reg;

    logic wr_en, ready, start, half_done, sclk_phase;

    // The read strobe and upper address/data bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{read, addr[4:2], wr_data[31:18]};

    assign wr_en     = cs & write;
    assign ready     = (state_reg == IDLE);
    assign start     = wr_en && (addr[1:0] == 2'd2) && ready;
    assign half_done = (c_reg == dvsr_s_reg);

    // Register file: slave selects and control fields, writable at any time.
    always_ff @(posedge clk) begin
        if (reset) begin
            ss_n_reg <= '1;
            dvsr_reg <= 16'h0000;
            cpol_reg <= 1'b0;
            cpha_reg <= 1'b0;
        end else if (wr_en) begin
            case (addr[1:0])
                2'd1: ss_n_reg <= wr_data[S-1:0];
                2'd3: begin
                    dvsr_reg <= wr_data[15:0];
                    cpol_reg <= wr_data[16];
                    cpha_reg <= wr_data[17];
                end
                default: ;
            endcase
        end
    end

    // Transfer parameters are frozen at start so ctrl writes apply to the next byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            dvsr_s_reg <= 16'h0000;
            cpol_s_reg <= 1'b0;
            cpha_s_reg <= 1'b0;
        end else if (start) begin
            dvsr_s_reg <= dvsr_reg;
            cpol_s_reg <= cpol_reg;
            cpha_s_reg <= cpha_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            c_reg        <= 16'h0000;
            n_reg        <= 3'd0;
            tx_shift_reg <= 8'h00;
            rx_shift_reg <= 8'h00;
            rx_data_reg  <= 8'h00;
        end else begin
            state_reg    <= state_next;
            c_reg        <= c_next;
            n_reg        <= n_next;
            tx_shift_reg <= tx_shift_next;
            rx_shift_reg <= rx_shift_next;
            rx_data_reg  <= rx_data_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        c_next        = c_reg;
        n_next        = n_reg;
        tx_shift_next = tx_shift_reg;
        rx_shift_next = rx_shift_reg;
        rx_data_next  = rx_data_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    tx_shift_next = wr_data[7:0];
                    c_next        = 16'h0000;
                    n_next        = 3'd0;
                    state_next    = cpha_reg ? CPHA_DLY : P0;
                end
            end
            CPHA_DLY: begin
                if (half_done) begin
                    c_next     = 16'h0000;
                    state_next = P0;
                end else begin
                    c_next = c_reg + 16'd1;
                end
            end
            P0: begin
                if (half_done) begin
                    rx_shift_next = {rx_shift_reg[6:0], spi_miso};
                    c_next        = 16'h0000;
                    state_next    = P1;
                end else begin
                    c_next = c_reg + 16'd1;
                end
            end
            P1: begin
                if (half_done) begin
                    c_next = 16'h0000;
                    if (n_reg == 3'd7) begin
                        rx_data_next = rx_shift_reg;
                        state_next   = IDLE;
                    end else begin
                        tx_shift_next = {tx_shift_reg[6:0], 1'b0};
                        n_next        = n_reg + 3'd1;
                        state_next    = P0;
                    end
                end else begin
                    c_next = c_reg + 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // While idle the clock rests at the programmed polarity so a new CPOL shows immediately.
    assign sclk_phase = ((state_reg == P1) && !cpha_s_reg) || ((state_reg == P0) && cpha_s_reg);
    assign spi_sclk   = (ready ? cpol_reg : cpol_s_reg) ^ sclk_phase;
    assign spi_mosi   = tx_shift_reg[7];
    assign spi_ss_n   = ss_n_reg;
    assign rd_data    = {23'b0, ready, rx_data_reg};

endmodule

// File: tb/tb_spi_master_core.sv
// Directed bench for spi_master_core: a table of byte transfers in several SPI
// modes plus hand-written register, slave-select and reset sequences.
module tb_spi_master_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cs = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [4:0]  addr = 5'd0;
    logic [31:0] wr_data = 32'd0;
    logic [31:0] rd_data;
    logic        spi_sclk, spi_mosi, spi_miso;
    logic [1:0]  spi_ss_n;

    spi_master_core #(.S(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .cs       (cs),
        .read     (read),
        .write    (write),
        .addr     (addr),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .spi_ss_n (spi_ss_n)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%08h", name, act);
        end
    endtask

    // Slave model: presents model_byte MSB first, advancing on the edge the
    // SPI mode designates for shifting out.
    logic       use_model = 1'b0;
    logic [7:0] model_byte = 8'h00;
    logic       cur_cpol = 1'b0;
    logic       cur_cpha = 1'b0;
    logic       sclk_prev = 1'b0;
    int lead_total = 0, trail_total = 0, lead_base = 0, trail_base = 0;
    int idx;
    logic model_bit;

    always @(negedge clk) begin
        if (spi_sclk !== sclk_prev) begin
            if (spi_sclk != cur_cpol) lead_total <= lead_total + 1;
            else                      trail_total <= trail_total + 1;
        end
        sclk_prev <= spi_sclk;
    end

    always_comb begin
        idx = 0;
        if (cur_cpha) idx = (lead_total == lead_base) ? 0 : lead_total - lead_base - 1;
        else          idx = trail_total - trail_base;
        model_bit = (idx >= 0 && idx < 8) ? model_byte[7-idx] : 1'b0;
    end

    assign spi_miso = use_model ? model_bit : spi_mosi;

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        @(negedge clk);
        cs = 1'b0; write = 1'b0;
    endtask

    typedef struct {
        logic [15:0] dvsr;
        logic        cpol;
        logic        cpha;
        logic [7:0]  tx;
        logic        use_model;
        logic [7:0]  model_byte;
        int          mid;       // 0 none, 1 busy data+ctrl writes, 2 start in completion cycle
        int          exp_len;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[7];

    task automatic run_vec(input vec_t v, input int vi);
        int k, first_k, rise_cnt, last_rise, bad_period;
        logic prev, done;
        cur_cpol   = v.cpol;
        cur_cpha   = v.cpha;
        use_model  = v.use_model;
        model_byte = v.model_byte;
        write_reg(5'd3, {14'b0, v.cpha, v.cpol, v.dvsr});
        @(negedge clk);
        lead_base  = lead_total;
        trail_base = trail_total;
        chk($sformatf("v%0d_sclk_idle", vi), {31'b0, spi_sclk}, {31'b0, v.cpol});
        prev = spi_sclk;
        cs = 1'b1; write = 1'b1; addr = 5'd2; wr_data = {24'b0, v.tx};
        k = 0; first_k = 0; rise_cnt = 0; last_rise = 0; bad_period = 0; done = 1'b0;
        while (!done && k < 2000) begin
            @(negedge clk);
            k++;
            cs = 1'b0; write = 1'b0;
            if (k == 1) begin
                chk($sformatf("v%0d_busy", vi), {31'b0, rd_data[8]}, 32'd0);
                chk($sformatf("v%0d_mosi_msb", vi), {31'b0, spi_mosi}, {31'b0, v.tx[7]});
            end
            if (spi_sclk != prev) begin
                if (first_k == 0) first_k = k;
                if (spi_sclk) begin
                    if (rise_cnt > 0 && (k - last_rise) != 2 * (int'(v.dvsr) + 1)) bad_period++;
                    rise_cnt++;
                    last_rise = k;
                end
            end
            prev = spi_sclk;
            if (rd_data[8]) begin
                done = 1'b1;
            end else begin
                if (v.mid == 1 && k == 10) begin
                    cs = 1'b1; write = 1'b1; addr = 5'd2; wr_data = 32'h0000_00FF;
                end
                if (v.mid == 1 && k == 20) begin
                    cs = 1'b1; write = 1'b1; addr = 5'd3; wr_data = {14'b0, v.cpha, v.cpol, 16'h0000};
                end
                if (v.mid == 2 && k == v.exp_len) begin
                    cs = 1'b1; write = 1'b1; addr = 5'd2; wr_data = 32'h0000_0055;
                end
            end
        end
        cs = 1'b0; write = 1'b0;
        chk($sformatf("v%0d_len", vi), k - 1, v.exp_len);
        chk($sformatf("v%0d_first_edge", vi), first_k, int'(v.dvsr) + 2);
        chk($sformatf("v%0d_rises", vi), rise_cnt, 8);
        chk($sformatf("v%0d_bad_periods", vi), bad_period, 0);
        chk($sformatf("v%0d_rd_data", vi), rd_data, v.exp_rd);
        @(negedge clk);
        chk($sformatf("v%0d_stays_idle", vi), rd_data, v.exp_rd);
    endtask

    initial begin
        //          dvsr    cpol  cpha  tx     model model  mid len exp rd_data
        vecs[0] = '{16'd3, 1'b0, 1'b0, 8'hA5, 1'b0, 8'h00, 0, 64, 32'h0000_01A5};
        vecs[1] = '{16'd1, 1'b1, 1'b1, 8'h00, 1'b1, 8'h3C, 0, 34, 32'h0000_013C};
        vecs[2] = '{16'd2, 1'b0, 1'b0, 8'h11, 1'b0, 8'h00, 1, 48, 32'h0000_0111};
        vecs[3] = '{16'd0, 1'b0, 1'b0, 8'h80, 1'b0, 8'h00, 2, 16, 32'h0000_0180};
        vecs[4] = '{16'd0, 1'b1, 1'b1, 8'h5A, 1'b0, 8'h00, 0, 17, 32'h0000_015A};
        vecs[5] = '{16'd1, 1'b1, 1'b0, 8'hC3, 1'b1, 8'h96, 0, 32, 32'h0000_0196};
        vecs[6] = '{16'd0, 1'b0, 1'b1, 8'h3C, 1'b1, 8'hE1, 0, 17, 32'h0000_01E1};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_rd_data", rd_data, 32'h0000_0100);
        chk("rst_sclk", {31'b0, spi_sclk}, 32'd0);
        chk("rst_mosi", {31'b0, spi_mosi}, 32'd0);
        chk("rst_ss_n", {30'b0, spi_ss_n}, 32'd3);

        write_reg(5'd1, 32'h0000_0002);
        chk("ss_n_write", {30'b0, spi_ss_n}, 32'd2);
        write_reg(5'd0, 32'hFFFF_FFFF);
        chk("addr0_ss_n", {30'b0, spi_ss_n}, 32'd2);
        chk("addr0_sclk", {31'b0, spi_sclk}, 32'd0);
        chk("addr0_rd_data", rd_data, 32'h0000_0100);
        for (int a = 0; a < 4; a++) begin
            @(negedge clk);
            cs = 1'b1; read = 1'b1; addr = 5'(a);
            @(negedge clk);
            chk($sformatf("read_addr%0d", a), rd_data, 32'h0000_0100);
            cs = 1'b0; read = 1'b0;
        end

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Reset partway into a mode-2 transfer, after five bits have gone out.
        use_model = 1'b0;
        cur_cpol  = 1'b1;
        write_reg(5'd3, {14'b0, 1'b0, 1'b1, 16'd3});
        write_reg(5'd2, 32'h0000_00A5);
        repeat (39) @(negedge clk);
        chk("pre_reset_busy", {31'b0, rd_data[8]}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_rd_data", rd_data, 32'h0000_0100);
        chk("midrst_sclk", {31'b0, spi_sclk}, 32'd0);
        chk("midrst_mosi", {31'b0, spi_mosi}, 32'd0);
        chk("midrst_ss_n", {30'b0, spi_ss_n}, 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
